// File: rtl/uart_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_ctrl
// Description : Bus-slave controller for one uart_tx / uart_rx pair. It holds
//               one byte pending transmit (double-buffered against the byte in
//               flight) and buffers received bytes in a small FIFO. It exposes
//               STATUS/DATA/CTRL registers and a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_ctrl #(
    parameter int RX_DEPTH = 4,
    parameter int RX_PTR_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       rdy,
    output logic       irq,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       tx_end,
    input  logic       rx_busy,
    input  logic       rx_end,
    input  logic [7:0] rx_data
);

    localparam logic [1:0] c_ADDR_STATUS = 2'd0;
    localparam logic [1:0] c_ADDR_DATA   = 2'd1;
    localparam logic [1:0] c_ADDR_CTRL   = 2'd2;
    localparam logic [RX_PTR_W:0] c_PTR_ONE = {{RX_PTR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_END  = 2'd3
    } tx_state_t;

    tx_state_t           r_state;
    tx_state_t           w_state_nxt;
    logic                w_tx_load;

    logic                r_hold_full;
    logic [7:0]          r_hold_data;
    logic [7:0]          r_tx_data;
    logic [1:0]          r_ctrl;
    logic                r_ovf;
    logic                r_drop;
    logic [RX_PTR_W:0]   r_wr_ptr;
    logic [RX_PTR_W:0]   r_rd_ptr;
    logic [7:0]          r_fifo_mem [RX_DEPTH];
    logic [7:0]          r_rd_data;
    logic                r_rdy;
    logic                r_irq;

    logic                w_wr;
    logic                w_rd;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic                w_pop;
    logic                w_push;
    logic                w_ovf_set;
    logic                w_ovf_clr;
    logic                w_drop_clr;
    logic                w_hold_free;
    logic                w_data_wr;
    logic                w_hold_load;
    logic                w_drop_set;
    logic                w_tx_act;
    logic [7:0]          w_status;
    logic [7:0]          w_rd_mux;

    assign w_wr         = cs & ~rw;
    assign w_rd         = cs & rw;
    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[RX_PTR_W] != r_rd_ptr[RX_PTR_W]) &&
                          (r_wr_ptr[RX_PTR_W-1:0] == r_rd_ptr[RX_PTR_W-1:0]);
    // A pop on an empty FIFO is a no-op; a push into a full FIFO succeeds
    // only when a pop frees the head slot in the same cycle.
    assign w_pop        = w_rd & (addr == c_ADDR_DATA) & ~w_fifo_empty;
    assign w_push       = rx_end & (~w_fifo_full | w_pop);
    assign w_ovf_set    = rx_end & w_fifo_full & ~w_pop;
    assign w_ovf_clr    = w_wr & (addr == c_ADDR_STATUS) & wr_data[2];
    assign w_drop_clr   = w_wr & (addr == c_ADDR_STATUS) & wr_data[5];
    // The holding byte is handed to the transmitter during START, so the
    // register is free to accept the next byte in that same cycle.
    assign w_hold_free  = ~r_hold_full | (r_state == ST_START);
    assign w_data_wr    = w_wr & (addr == c_ADDR_DATA);
    assign w_hold_load  = w_data_wr & w_hold_free;
    assign w_drop_set   = w_data_wr & ~w_hold_free;
    assign w_tx_act     = r_hold_full | (r_state != ST_IDLE);
    assign w_status     = {2'b00, r_drop, r_ovf, rx_busy, w_tx_act,
                           w_fifo_full, ~w_fifo_empty};

    // Read-data selection for the access being performed this cycle
    always_comb begin
        w_rd_mux = 8'h00;
        if (w_rd) begin
            case (addr)
                c_ADDR_STATUS: w_rd_mux = w_status;
                c_ADDR_DATA:   w_rd_mux = w_pop ? r_fifo_mem[r_rd_ptr[RX_PTR_W-1:0]] : 8'h00;
                c_ADDR_CTRL:   w_rd_mux = {6'b000000, r_ctrl};
                default:       w_rd_mux = 8'h00;
            endcase
        end
    end

    // Transmit sequencer next state; a pending byte after tx_end starts at once
    always_comb begin
        w_state_nxt = r_state;
        w_tx_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_hold_full) begin
                    w_state_nxt = ST_START;
                    w_tx_load   = 1'b1;
                end
            end
            ST_START: w_state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (tx_busy) w_state_nxt = ST_WAIT_END;
            end
            ST_WAIT_END: begin
                if (tx_end) begin
                    if (r_hold_full) begin
                        w_state_nxt = ST_START;
                        w_tx_load   = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sequencer state, holding register and latched transmit byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_hold_full <= 1'b0;
            r_hold_data <= 8'h00;
            r_tx_data   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_tx_load) r_tx_data <= r_hold_data;
            if (w_hold_load) begin
                r_hold_full <= 1'b1;
                r_hold_data <= wr_data;
            end else if (r_state == ST_START) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // Control register, sticky error flags and FIFO pointers (set beats clear)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl   <= 2'b00;
            r_ovf    <= 1'b0;
            r_drop   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr && (addr == c_ADDR_CTRL)) r_ctrl <= wr_data[1:0];
            if (w_ovf_set)       r_ovf <= 1'b1;
            else if (w_ovf_clr)  r_ovf <= 1'b0;
            if (w_drop_set)      r_drop <= 1'b1;
            else if (w_drop_clr) r_drop <= 1'b0;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr[RX_PTR_W-1:0]] <= rx_data;
    end

    // Registered bus response and interrupt level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= 8'h00;
            r_rdy     <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_rd_data <= w_rd_mux;
            r_rdy     <= cs;
            r_irq     <= (r_ctrl[0] & ~w_fifo_empty) | (r_ctrl[1] & ~w_tx_act) | r_ovf;
        end
    end

    assign rd_data  = r_rd_data;
    assign rdy      = r_rdy;
    assign irq      = r_irq;
    assign tx_start = (r_state == ST_START);
    assign tx_data  = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_ctrl
// Description : Self-checking bench for uart_ctrl: directed scenarios followed
//               by randomized bus/UART traffic, all outputs compared every
//               cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_ctrl;

    localparam int c_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs, rw, tx_busy, tx_end, rx_busy, rx_end;
    logic [1:0] addr;
    logic [7:0] wr_data, rx_data;
    logic [7:0] rd_data, tx_data;
    logic       rdy, irq, tx_start;

    int n_vec = 0;
    int n_err = 0;

    uart_ctrl #(.RX_DEPTH(4), .RX_PTR_W(2)) dut (
        .clk(clk), .reset(reset), .cs(cs), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rdy(rdy), .irq(irq),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .tx_end(tx_end), .rx_busy(rx_busy), .rx_end(rx_end), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_hold_v;
    bit [7:0]   m_hold_b;
    bit         m_pulse;
    bit         m_inflight;
    bit         m_got_busy;
    bit [1:0]   m_ctrl;
    bit         m_ovf, m_drop;
    bit [7:0]   m_rd, m_txd;
    bit         m_rdy, m_irq;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_hold_v = 0; m_hold_b = 0; m_pulse = 0; m_inflight = 0; m_got_busy = 0;
        m_ctrl = 0; m_ovf = 0; m_drop = 0; m_rd = 0; m_txd = 0; m_rdy = 0; m_irq = 0;
    endtask

    // One clock edge worth of behaviour, from the register-level rules
    task automatic model_step();
        bit       busy_tx, pop, ovf_set, ovf_clr, drop_set, drop_clr, loaded, hold_after, irq_n;
        bit [7:0] rd_v;
        logic [7:0] dummy;
        busy_tx = m_hold_v || m_inflight;
        irq_n   = (m_ctrl[0] && m_q.size() != 0) || (m_ctrl[1] && !busy_tx) || m_ovf;
        rd_v = 8'h00;
        pop  = 0;
        if (cs && rw) begin
            case (addr)
                2'd0: rd_v = {2'b00, m_drop, m_ovf, rx_busy, busy_tx,
                              m_q.size() == c_DEPTH, m_q.size() != 0};
                2'd1: if (m_q.size() != 0) begin rd_v = m_q[0]; pop = 1; end
                2'd2: rd_v = {6'b000000, m_ctrl};
                default: rd_v = 8'h00;
            endcase
        end
        ovf_set = rx_end && (m_q.size() == c_DEPTH) && !pop;
        if (pop) dummy = m_q.pop_front();
        if (rx_end && !ovf_set) m_q.push_back(rx_data);
        ovf_clr  = cs && !rw && addr == 2'd0 && wr_data[2];
        drop_clr = cs && !rw && addr == 2'd0 && wr_data[5];
        loaded = 0; drop_set = 0;
        if (cs && !rw && addr == 2'd1) begin
            if (!m_hold_v || m_pulse) loaded = 1;
            else drop_set = 1;
        end
        if (cs && !rw && addr == 2'd2) m_ctrl = wr_data[1:0];
        hold_after = m_hold_v;
        if (m_pulse) begin
            m_pulse = 0; m_got_busy = 0; hold_after = 0;
        end else if (m_inflight && !m_got_busy) begin
            if (tx_busy) m_got_busy = 1;
        end else if (m_inflight) begin
            if (tx_end) begin
                m_inflight = 0;
                if (m_hold_v) begin m_pulse = 1; m_inflight = 1; m_txd = m_hold_b; end
            end
        end else if (m_hold_v) begin
            m_pulse = 1; m_inflight = 1; m_txd = m_hold_b;
        end
        m_hold_v = loaded ? 1'b1 : hold_after;
        if (loaded) m_hold_b = wr_data;
        m_ovf  = ovf_set  ? 1'b1 : (ovf_clr  ? 1'b0 : m_ovf);
        m_drop = drop_set ? 1'b1 : (drop_clr ? 1'b0 : m_drop);
        m_rd = rd_v; m_rdy = cs; m_irq = irq_n;
    endtask

    task automatic compare_all();
        check_val("rd_data",  rd_data,             m_rd);
        check_val("rdy",      {7'b0, rdy},         {7'b0, m_rdy});
        check_val("irq",      {7'b0, irq},         {7'b0, m_irq});
        check_val("tx_start", {7'b0, tx_start},    {7'b0, m_pulse});
        check_val("tx_data",  tx_data,             m_txd);
    endtask

    task automatic step(input logic c, input logic r, input logic [1:0] a, input logic [7:0] wd,
                        input logic re, input logic [7:0] rxd, input logic tb, input logic te,
                        input logic rb);
        cs = c; rw = r; addr = a; wr_data = wd; rx_end = re; rx_data = rxd;
        tx_busy = tb; tx_end = te; rx_busy = rb;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();                             step(0, 0, 2'd0, 8'h00, 0, 8'h00, 0, 0, 0); endtask
    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d); step(1, 0, a, d, 0, 8'h00, 0, 0, 0); endtask
    task automatic bus_rd(input logic [1:0] a);        step(1, 1, a, 8'h00, 0, 8'h00, 0, 0, 0); endtask
    task automatic rx_push(input logic [7:0] d);       step(0, 0, 2'd0, 8'h00, 1, d, 0, 0, 0); endtask
    task automatic txb();                              step(0, 0, 2'd0, 8'h00, 0, 8'h00, 1, 0, 0); endtask
    task automatic txe();                              step(0, 0, 2'd0, 8'h00, 0, 8'h00, 0, 1, 0); endtask

    task automatic do_reset();
        reset = 1'b1;
        cs = 0; rw = 0; addr = 0; wr_data = 0; rx_end = 0; rx_data = 0;
        tx_busy = 0; tx_end = 0; rx_busy = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // Reset state: STATUS reads zero
        bus_rd(2'd0);
        check_val("status_after_reset", rd_data, 8'h00);

        // Single transmit
        bus_wr(2'd1, 8'hA5);
        idle();
        check_val("tx_start_a5", {7'b0, tx_start}, 8'h01);
        check_val("tx_data_a5", tx_data, 8'hA5);
        idle(); txb(); txe();
        bus_rd(2'd0);
        check_val("status_tx_idle", rd_data, 8'h00);

        // Back-to-back transmit with a dropped third byte
        bus_wr(2'd1, 8'h11);
        idle(); idle(); txb();
        bus_wr(2'd1, 8'h22);
        bus_wr(2'd1, 8'h33);
        txe();
        check_val("tx_start_22", {7'b0, tx_start}, 8'h01);
        check_val("tx_data_22", tx_data, 8'h22);
        idle(); txb(); txe();
        bus_rd(2'd0);
        check_val("status_drop", rd_data, 8'h20);
        bus_wr(2'd0, 8'h20);

        // RX fill and overflow
        for (int i = 1; i <= 4; i++) rx_push(8'(i));
        bus_rd(2'd0);
        check_val("status_full", rd_data, 8'h03);
        rx_push(8'h05);
        bus_rd(2'd0);
        check_val("status_ovf", rd_data, 8'h13);
        for (int i = 1; i <= 5; i++) begin
            bus_rd(2'd1);
            check_val("rx_drain", rd_data, (i == 5) ? 8'h00 : 8'(i));
        end
        bus_wr(2'd0, 8'h04);
        bus_rd(2'd0);
        check_val("status_ovf_clr", rd_data, 8'h00);

        // Pop coincident with push while full
        for (int i = 0; i < 4; i++) rx_push(8'hA0 + 8'(i));
        step(1, 1, 2'd1, 8'h00, 1, 8'h77, 0, 0, 0);
        check_val("simul_pop", rd_data, 8'hA0);
        bus_rd(2'd0);
        check_val("status_simul", rd_data, 8'h03);
        for (int i = 0; i < 4; i++) begin
            bus_rd(2'd1);
            check_val("simul_drain", rd_data, (i == 3) ? 8'h77 : (8'hA1 + 8'(i)));
        end

        // Interrupt sources
        bus_wr(2'd2, 8'h01);
        rx_push(8'h5A);
        idle();
        check_val("irq_rx", {7'b0, irq}, 8'h01);
        bus_rd(2'd1);
        idle();
        check_val("irq_rx_clr", {7'b0, irq}, 8'h00);
        bus_wr(2'd2, 8'h02);
        idle();
        check_val("irq_tx", {7'b0, irq}, 8'h01);
        bus_rd(2'd2);
        check_val("ctrl_rd", rd_data, 8'h02);

        // Randomized traffic, occasional mid-frame reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 8'($urandom), $urandom_range(0, 2) == 0, 8'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
